// File: rtl/mm_arbiter_pkg.sv
// mm_arbiter_pkg: shared state encoding, master index type and default widths
package mm_arbiter_pkg;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  typedef enum logic [1:0] {IDLE, CMD, RESP} state_e;
  typedef logic mst_t;
endpackage

// File: rtl/mm_arbiter2_rr.sv
// rr_arbiter2: combinational two-way round-robin pick; a sole requester always wins
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       gnt_o
);
  assign gnt_o = &req_i ? ~last_i : req_i[1];
endmodule

// File: rtl/mm_arbiter2.sv
// mm_arbiter2: shares one Avalon-MM slave between m0 (JTAG bridge) and m1 (CPU data port),
// one transaction outstanding at a time, round-robin on contention.
module mm_arbiter2 import mm_arbiter_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  input  logic [ADDR_WIDTH-1:0]   m0_address,
  input  logic                    m0_read,
  input  logic                    m0_write,
  input  logic [DATA_WIDTH-1:0]   m0_writedata,
  input  logic [DATA_WIDTH/8-1:0] m0_byteenable,
  output logic                    m0_waitrequest,
  output logic [DATA_WIDTH-1:0]   m0_readdata,
  output logic                    m0_readdatavalid,
  input  logic [ADDR_WIDTH-1:0]   m1_address,
  input  logic                    m1_read,
  input  logic                    m1_write,
  input  logic [DATA_WIDTH-1:0]   m1_writedata,
  input  logic [DATA_WIDTH/8-1:0] m1_byteenable,
  output logic                    m1_waitrequest,
  output logic [DATA_WIDTH-1:0]   m1_readdata,
  output logic                    m1_readdatavalid,
  output logic [ADDR_WIDTH-1:0]   s_address,
  output logic                    s_read,
  output logic                    s_write,
  output logic [DATA_WIDTH-1:0]   s_writedata,
  output logic [DATA_WIDTH/8-1:0] s_byteenable,
  input  logic                    s_waitrequest,
  input  logic [DATA_WIDTH-1:0]   s_readdata,
  input  logic                    s_readdatavalid
);
  localparam int BW = DATA_WIDTH / 8;
  state_e state_q, state_d;
  mst_t owner_q, last_grant_q, win;
  logic wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BW-1:0] be_q;
  logic [1:0] req;
  logic in_cmd, in_resp, accept, rvalid;

  assign req = {m1_read | m1_write, m0_read | m0_write};

  rr_arbiter2 u_rr (
    .req_i  (req),
    .last_i (last_grant_q),
    .gnt_o  (win)
  );

  assign in_cmd  = state_q == CMD;
  assign in_resp = state_q == RESP;
  assign accept  = in_cmd & ~s_waitrequest;
  assign rvalid  = in_resp & s_readdatavalid;

  always_comb
    state_d = state_q == IDLE ? (|req ? CMD : IDLE) :
              in_cmd ? (s_waitrequest ? CMD : (wr_q ? IDLE : RESP)) :
              in_resp ? (s_readdatavalid ? IDLE : RESP) : IDLE;

  // Write wins when read and write are both asserted, so only the write flag is latched
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && |req) begin
        owner_q      <= win;
        last_grant_q <= win;
        wr_q         <= win ? m1_write : m0_write;
        addr_q       <= win ? m1_address : m0_address;
        wdata_q      <= win ? m1_writedata : m0_writedata;
        be_q         <= win ? m1_byteenable : m0_byteenable;
      end
    end
  end

  assign s_read       = in_cmd & ~wr_q;
  assign s_write      = in_cmd & wr_q;
  assign s_address    = in_cmd ? addr_q : '0;
  assign s_writedata  = in_cmd ? wdata_q : '0;
  assign s_byteenable = in_cmd ? be_q : '0;

  assign m0_waitrequest   = ~(accept & ~owner_q);
  assign m1_waitrequest   = ~(accept & owner_q);
  assign m0_readdatavalid = rvalid & ~owner_q;
  assign m1_readdatavalid = rvalid & owner_q;
  assign m0_readdata      = m0_readdatavalid ? s_readdata : '0;
  assign m1_readdata      = m1_readdatavalid ? s_readdata : '0;
endmodule

// File: tb/tb_mm_arbiter2.sv
// tb_mm_arbiter2: vector table, directed corner sequences and a randomized run checked
// against a transaction-level reference model of the arbiter.
module tb_mm_arbiter2;
  localparam logic [31:0] D0 = 32'hDEADBEEF;
  localparam logic [31:0] D1 = 32'h0BADF00D;
  localparam logic [137:0] IDLE_V = {2'b00, 68'h0, 2'b11, 66'h0};

  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] m0_address, m1_address, m0_writedata, m1_writedata, s_readdata;
  logic [3:0] m0_byteenable, m1_byteenable;
  logic m0_read, m0_write, m1_read, m1_write, s_waitrequest, s_readdatavalid;
  logic m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata, s_address, s_writedata;
  logic [3:0] s_byteenable;
  logic s_read, s_write;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mm_arbiter2 dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata),
    .s_byteenable(s_byteenable), .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid)
  );

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [159:0] outs();
    return {s_read, s_write, s_address, s_writedata, s_byteenable, m1_waitrequest, m0_waitrequest,
            m1_readdatavalid, m0_readdatavalid, m1_readdata, m0_readdata};
  endfunction

  // Reference model: one transaction in flight, tracked as granted/awaiting-data plus a command snapshot
  bit mdl_on = 1'b0;
  bit busy, resp_wait, owner, last_g, c_wr;
  logic [31:0] c_a, c_d;
  logic [3:0] c_be;
  always @(negedge clk) begin : model
    logic cmd, acc, v;
    logic [1:0] req;
    logic [159:0] e;
    #2;
    cmd = busy && !resp_wait;
    acc = cmd && !s_waitrequest;
    v = resp_wait && s_readdatavalid;
    e = {cmd && !c_wr, cmd && c_wr, cmd ? c_a : 32'h0, cmd ? c_d : 32'h0, cmd ? c_be : 4'h0,
         !(acc && owner), !(acc && !owner), v && owner, v && !owner,
         (v && owner) ? s_readdata : 32'h0, (v && !owner) ? s_readdata : 32'h0};
    if (mdl_on) chk("model", outs(), e);
    req = {m1_read || m1_write, m0_read || m0_write};
    if (!rst_n) begin
      busy = 1'b0; resp_wait = 1'b0; owner = 1'b0; last_g = 1'b1; mdl_on = 1'b1;
    end else if (!busy) begin
      if (req != 2'b00) begin
        owner = (req == 2'b11) ? !last_g : req[1];
        last_g = owner;
        busy = 1'b1;
        c_wr = owner ? m1_write : m0_write;
        c_a = owner ? m1_address : m0_address;
        c_d = owner ? m1_writedata : m0_writedata;
        c_be = owner ? m1_byteenable : m0_byteenable;
      end
    end else if (!resp_wait) begin
      if (acc) begin
        if (c_wr) busy = 1'b0;
        else resp_wait = 1'b1;
      end
    end else if (v) begin
      busy = 1'b0; resp_wait = 1'b0;
    end
  end

  typedef struct {
    bit rn; bit [1:0] c0, c1; logic [31:0] a0; bit sw, sv; logic [31:0] sd;
    bit [1:0] e_s; logic [31:0] e_a, e_d; bit [1:0] e_w, e_v; logic [31:0] e_r0, e_r1;
  } vec_t;

  function automatic vec_t mk(input bit rn, input bit [1:0] c0, c1, input logic [31:0] a0,
                              input bit sw, sv, input logic [31:0] sd, input bit [1:0] e_s,
                              input logic [31:0] e_a, e_d, input bit [1:0] e_w, e_v,
                              input logic [31:0] e_r0, e_r1);
    return '{rn, c0, c1, a0, sw, sv, sd, e_s, e_a, e_d, e_w, e_v, e_r0, e_r1};
  endfunction

  task automatic idle_in();
    m0_read = 1'b0; m0_write = 1'b0; m0_address = '0; m0_writedata = D0; m0_byteenable = 4'hF;
    m1_read = 1'b0; m1_write = 1'b0; m1_address = '0; m1_writedata = D1; m1_byteenable = 4'hF;
    s_waitrequest = 1'b0; s_readdatavalid = 1'b0; s_readdata = '0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    idle_in();
    @(negedge clk);
  endtask

  vec_t tbl[13];
  int ng, nv0, nv1, outst, rounds, k, lat;
  bit p0, p1, due;
  bit order[16];
  logic [31:0] dval;
  bit pend[2], rq_rd[2], rq_wr[2];
  logic [31:0] rq_a[2], rq_d[2];
  logic [3:0] rq_be[2];

  initial begin
    rst_n = 1'b0;
    idle_in();
    tbl[0]  = mk(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0, '0, 2'b11, '0, '0, '0);
    tbl[1]  = mk(1'b1, 2'b01, '0, 32'h4, 1'b0, 1'b0, '0, '0, '0, '0, 2'b11, '0, '0, '0);
    tbl[2]  = mk(1'b1, 2'b01, '0, 32'h4, 1'b0, 1'b0, '0, 2'b01, 32'h4, D0, 2'b10, '0, '0, '0);
    tbl[3]  = mk(1'b1, '0, '0, 32'h4, 1'b0, 1'b0, '0, '0, '0, '0, 2'b11, '0, '0, '0);
    tbl[4]  = mk(1'b1, 2'b11, '0, 32'hC, 1'b1, 1'b0, '0, '0, '0, '0, 2'b11, '0, '0, '0);
    tbl[5]  = mk(1'b1, 2'b11, '0, 32'hC, 1'b1, 1'b0, '0, 2'b01, 32'hC, D0, 2'b11, '0, '0, '0);
    tbl[6]  = mk(1'b1, 2'b11, '0, 32'hC, 1'b0, 1'b0, '0, 2'b01, 32'hC, D0, 2'b10, '0, '0, '0);
    tbl[7]  = mk(1'b1, '0, '0, 32'hC, 1'b0, 1'b1, 32'h55555555, '0, '0, '0, 2'b11, '0, '0, '0);
    tbl[8]  = mk(1'b1, '0, 2'b10, '0, 1'b0, 1'b1, 32'h66666666, '0, '0, '0, 2'b11, '0, '0, '0);
    tbl[9]  = mk(1'b1, '0, 2'b10, '0, 1'b0, 1'b1, 32'h77777777, 2'b10, 32'h8, D1, 2'b01, '0, '0, '0);
    tbl[10] = mk(1'b1, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0, '0, 2'b11, '0, '0, '0);
    tbl[11] = mk(1'b1, '0, '0, '0, 1'b0, 1'b1, 32'h12345678, '0, '0, '0, 2'b11, 2'b10, '0, 32'h12345678);
    tbl[12] = mk(1'b1, '0, '0, '0, 1'b0, 1'b1, 32'h9, '0, '0, '0, 2'b11, '0, '0, '0);

    reset_dut();
    m1_address = 32'h8;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      rst_n = tbl[i].rn;
      {m0_read, m0_write} = tbl[i].c0;
      {m1_read, m1_write} = tbl[i].c1;
      m0_address = tbl[i].a0;
      s_waitrequest = tbl[i].sw;
      s_readdatavalid = tbl[i].sv;
      s_readdata = tbl[i].sd;
      #1;
      chk($sformatf("vec%0d", i), outs(),
          {tbl[i].e_s, tbl[i].e_a, tbl[i].e_d, (tbl[i].e_s != 2'b00) ? 4'hF : 4'h0,
           tbl[i].e_w, tbl[i].e_v, tbl[i].e_r1, tbl[i].e_r0});
    end

    // m1 read stalled three cycles by the slave, data two cycles after acceptance
    reset_dut();
    @(negedge clk);
    rst_n = 1'b1; m1_read = 1'b1; m1_address = 32'h8; s_waitrequest = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      s_waitrequest = (c < 4);
      #1;
      chk($sformatf("stall_cmd%0d", c), {s_read, s_write, s_address}, {2'b10, 32'h8});
      chk($sformatf("stall_wait%0d", c), {m0_waitrequest, m1_waitrequest}, {1'b1, c < 4});
    end
    @(negedge clk);
    m1_read = 1'b0; s_waitrequest = 1'b0;
    #1;
    chk("stall_resp_idle", {s_read, s_write, m0_readdatavalid, m1_readdatavalid}, 4'b0000);
    @(negedge clk);
    s_readdatavalid = 1'b1; s_readdata = 32'h12345678;
    #1;
    chk("stall_data", {m0_readdatavalid, m1_readdatavalid, m1_readdata, m0_readdata},
        {2'b01, 32'h12345678, 32'h0});
    @(negedge clk);
    s_readdatavalid = 1'b0;
    #1;
    chk("stall_after", {m0_readdatavalid, m1_readdatavalid}, 2'b00);

    // reset while awaiting read data: the late data must be dropped
    reset_dut();
    @(negedge clk);
    rst_n = 1'b1; m0_read = 1'b1; m0_address = 32'h30;
    #1;
    chk("rst_idle_wait", {m0_waitrequest, m1_waitrequest}, 2'b11);
    @(negedge clk);
    #1;
    chk("rst_accept", {s_read, m0_waitrequest}, 2'b10);
    @(negedge clk);
    m0_read = 1'b0; rst_n = 1'b0;
    #1;
    chk("rst_in_resp", {m0_readdatavalid, m1_readdatavalid}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1; s_readdatavalid = 1'b1; s_readdata = 32'hAAAA5555;
    #1;
    chk("rst_late_data", outs(), IDLE_V);
    @(negedge clk);
    s_readdatavalid = 1'b0;
    #1;
    chk("rst_after", outs(), IDLE_V);

    // simultaneous reads from both masters, four rounds
    reset_dut();
    ng = 0; nv0 = 0; nv1 = 0; outst = 0; rounds = 0; p0 = 1'b0; p1 = 1'b0; due = 1'b0; dval = '0;
    for (int c = 0; c < 300; c++) begin
      if (ng >= 8 && outst == 0) break;
      @(negedge clk);
      rst_n = 1'b1;
      if (!p0 && !p1 && outst == 0 && rounds < 4) begin
        p0 = 1'b1; p1 = 1'b1; rounds++;
      end
      m0_read = p0; m0_address = 32'h10; m1_read = p1; m1_address = 32'h20;
      s_waitrequest = 1'b0; s_readdatavalid = due; s_readdata = dval;
      #1;
      if (m0_readdatavalid) begin nv0++; outst--; chk("rr_data_m0", m0_readdata, dval); end
      if (m1_readdatavalid) begin nv1++; outst--; chk("rr_data_m1", m1_readdata, dval); end
      due = 1'b0;
      if (p0 && !m0_waitrequest && ng < 16) begin
        order[ng] = 1'b0; ng++; p0 = 1'b0; due = 1'b1; outst++; dval = $urandom;
      end
      if (p1 && !m1_waitrequest && ng < 16) begin
        order[ng] = 1'b1; ng++; p1 = 1'b0; due = 1'b1; outst++; dval = $urandom;
      end
    end
    chk("rr_grants", ng, 8);
    for (int i = 0; i < 8; i++) chk($sformatf("rr_order%0d", i), order[i], i % 2);
    chk("rr_rdv_m0", nv0, 4);
    chk("rr_rdv_m1", nv1, 4);

    // randomized traffic with random stalls, latencies, spurious valids and resets
    reset_dut();
    lat = 0;
    for (int i = 0; i < 2; i++) pend[i] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 249) != 0);
      for (int i = 0; i < 2; i++)
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          k = $urandom_range(0, 4);
          rq_rd[i] = (k < 2 || k == 4);
          rq_wr[i] = (k >= 2);
          rq_a[i] = $urandom; rq_d[i] = $urandom; rq_be[i] = 4'($urandom);
        end
      m0_read = pend[0] && rq_rd[0]; m0_write = pend[0] && rq_wr[0];
      m0_address = rq_a[0]; m0_writedata = rq_d[0]; m0_byteenable = rq_be[0];
      m1_read = pend[1] && rq_rd[1]; m1_write = pend[1] && rq_wr[1];
      m1_address = rq_a[1]; m1_writedata = rq_d[1]; m1_byteenable = rq_be[1];
      s_waitrequest = ($urandom_range(0, 1) == 0);
      if (lat > 0) begin
        lat--;
        s_readdatavalid = (lat == 0);
      end else s_readdatavalid = ($urandom_range(0, 15) == 0);
      s_readdata = $urandom;
      #1;
      if (s_read && !s_waitrequest) lat = $urandom_range(1, 3);
      if (pend[0] && !m0_waitrequest) pend[0] = 1'b0;
      if (pend[1] && !m1_waitrequest) pend[1] = 1'b0;
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mm_arbiter2.md
MM_ARBITER2 -- requirements
Module: mm_arbiter2

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, address width of all ports.
REQ-002 Parameter DATA_WIDTH, default 32, data width; byteenable width is DATA_WIDTH/8.
REQ-003 clk_clk  in  1  single clock; all logic on rising edge.
REQ-004 reset_reset_n  in  1  reset, synchronous, active-low.
REQ-005 m0_address/m1_address  in  ADDR_WIDTH  master address; m0 is the JTAG bridge, m1 is the CPU data port.
REQ-006 m0_read/m1_read, m0_write/m1_write  in  1  master command strobes.
REQ-007 m0_writedata/m1_writedata  in  DATA_WIDTH; m0_byteenable/m1_byteenable  in  DATA_WIDTH/8.
REQ-008 m0_waitrequest/m1_waitrequest  out  1  command stall, Avalon-MM semantics.
REQ-009 m0_readdata/m1_readdata  out  DATA_WIDTH; m0_readdatavalid/m1_readdatavalid  out  1.
REQ-010 s_address, s_read, s_write, s_writedata, s_byteenable  out  widths as above  slave command.
REQ-011 s_waitrequest, s_readdata, s_readdatavalid  in  1/DATA_WIDTH/1  slave response.

Function
REQ-012 FSM states: IDLE, CMD, RESP; encoding in the shared package.
REQ-013 IDLE: if any master asserts read or write, register winner into owner, latch its command, go to CMD; otherwise stay.
REQ-014 Arbitration is round-robin: on contention the grant goes to the master not granted last; last_grant resets to 1, so m0 wins the first contention.
REQ-015 A sole requester always wins, whatever last_grant holds.
REQ-016 CMD: drive s_* from the latched command; hold it stable while s_waitrequest=1.
REQ-017 CMD, s_waitrequest=0: a write goes to IDLE; a read goes to RESP; the owner's waitrequest is 0 in that same cycle.
REQ-018 RESP: s_read=s_write=0; on s_readdatavalid=1 drive owner readdata=s_readdata and readdatavalid=1 for exactly one cycle, then go to IDLE.
REQ-019 Each master's waitrequest is 1 in every cycle except its accept cycle (REQ-017); the non-owner's waitrequest is always 1.
REQ-020 readdatavalid is never asserted to the non-owner; the non-owner's readdata is 0.
REQ-021 At most one transaction is outstanding; minimum cost is 2 cycles for a write and 3 for a read.
REQ-022 If a master asserts read and write together, the write is performed and the read is discarded.
REQ-023 s_readdatavalid outside RESP is ignored.
REQ-024 A master must hold its command until its waitrequest=0; commands dropped before acceptance are not required to complete.
REQ-025 last_grant updates on entry to CMD.

Reset
REQ-026 reset_reset_n=0 on a clock edge sets state=IDLE, last_grant=1, all s_read/s_write=0, all m*_readdatavalid=0, all m*_waitrequest=1, all data outputs 0.
REQ-027 Reset during CMD or RESP abandons the transaction; no readdatavalid is issued for it afterwards.
REQ-028 First arbitration occurs in the first cycle after reset deasserts.

Structure
REQ-029 Package mm_arbiter_pkg holds the state enum, the master-index type and default widths.
REQ-030 One sub-module, rr_arbiter2: combinational 2-way round-robin winner from requests and last_grant.
REQ-031 Command latch, FSM and response routing live in mm_arbiter2; no other hierarchy.

Verification
REQ-032 m0 writes 0xDEADBEEF to address 0x4 with byteenable 0xF, slave waitrequest=0 -> s_write for 1 cycle with the same data; m0_waitrequest=0 in that cycle; back in IDLE the next cycle.
REQ-033 m0 and m1 read in the same cycle, repeated 4 times -> grant order m0, m1, m0, m1; each gets exactly one readdatavalid carrying the slave data.
REQ-034 m1 reads 0x8, slave holds waitrequest=1 for 3 cycles, then returns 0x12345678 two cycles later -> s_* stable for 4 cycles; m1_readdatavalid=1 once with 0x12345678; m0_readdatavalid stays 0.
REQ-035 Reset asserted in RESP before s_readdatavalid, slave returns data afterwards -> no m*_readdatavalid; outputs match REQ-026.
REQ-036 m0 asserts read and write together to 0xC -> only s_write is issued; no readdatavalid.
REQ-037 Spurious s_readdatavalid=1 while IDLE -> no master readdatavalid.
